// File: rtl/irq_controller.sv
// Eight-source prioritised interrupt controller with edge-latched pending,
// nesting by in-service priority and a two-cycle request/acknowledge handshake.
module irq_controller #(
    parameter logic [7:0] RESET_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq,
    input  logic        intack,
    input  logic        wren,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        int_out,
    output logic [15:0] vector
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;

    logic [7:0]  irq_q;
    logic [7:0]  pending;
    logic [7:0]  pending_d;
    logic [7:0]  mask;
    logic [7:0]  insvc;
    logic [7:0]  insvc_d;

    logic        int_q;
    logic        int_d;
    logic [2:0]  vec_q;
    logic [2:0]  vec_d;
    logic        ack_fire;

    logic [7:0]  rise;
    logic [7:0]  ins_low;
    logic [7:0]  prio;
    logic [7:0]  eligible;
    logic [7:0]  ack_bit;
    logic [7:0]  w1c;
    logic [7:0]  eoi_clr;

    logic        unused_din;

    assign unused_din = ^din[15:8];

    function automatic logic [2:0] lsb_idx(input logic [7:0] v);
        lsb_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lsb_idx = 3'(i);
        end
    endfunction

    assign rise = irq & ~irq_q;

    // Only sources strictly above the highest-priority in-service one may nest.
    assign ins_low  = insvc & (~insvc + 8'd1);
    assign prio     = (insvc == 8'd0) ? 8'hFF : (ins_low - 8'd1);
    assign eligible = pending & mask & prio;

    always_comb begin
        state_d  = state;
        int_d    = int_q;
        vec_d    = vec_q;
        ack_fire = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != 8'd0) begin
                    vec_d   = lsb_idx(eligible);
                    int_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    int_d = 1'b0;
                end
            end
            REQ: begin
                if (intack) begin
                    ack_fire = 1'b1;
                    int_d    = 1'b0;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!intack) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w1c     = 8'd0;
        eoi_clr = 8'd0;
        if (wren && addr == 2'd1) w1c = din[7:0];
        if (wren && addr == 2'd2) eoi_clr = ins_low;
    end

    // Acknowledge uses the latched vector, even if its pending bit was cleared.
    assign ack_bit   = ack_fire ? (8'd1 << vec_q) : 8'd0;
    assign pending_d = (pending & ~(w1c | ack_bit)) | rise;
    assign insvc_d   = (insvc & ~eoi_clr) | ack_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_q   <= 8'd0;
            pending <= 8'd0;
            mask    <= RESET_MASK;
            insvc   <= 8'd0;
            int_q   <= 1'b0;
            vec_q   <= 3'd0;
        end else begin
            state   <= state_d;
            irq_q   <= irq;
            pending <= pending_d;
            insvc   <= insvc_d;
            int_q   <= int_d;
            vec_q   <= vec_d;
            if (wren && addr == 2'd0) mask <= din[7:0];
        end
    end

    always_comb begin
        dout = 16'd0;
        case (addr)
            2'd0:    dout = {8'd0, mask};
            2'd1:    dout = {8'd0, pending};
            2'd2:    dout = {8'd0, insvc};
            default: dout = {11'd0, int_q, state, vec_q};
        endcase
    end

    assign int_out = int_q;
    assign vector  = {13'd0, vec_q};

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus queues expected register views,
// a negedge monitor pops and compares them against the DUT.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        intack;
    logic        wren;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        int_out;
    logic [15:0] vector;

    typedef struct {
        string       name;
        logic [15:0] d;
        logic        i;
        logic [2:0]  v;
    } exp_t;

    exp_t q[$];
    logic sample = 1'b0;
    int   checks = 0;
    int   errors = 0;

    irq_controller #(.RESET_MASK(8'hFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .intack  (intack),
        .wren    (wren),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .int_out (int_out),
        .vector  (vector)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL no_expected: monitor sampled with empty queue");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (dout !== e.d || int_out !== e.i ||
                    vector !== {13'd0, e.v}) begin
                    errors++;
                    $display("FAIL %s: dout=%h int_out=%b vector=%h, expected dout=%h int_out=%b vector=%h",
                             e.name, dout, int_out, vector, e.d, e.i, {13'd0, e.v});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [1:0] a,
                       input logic [15:0] d, input logic i,
                       input logic [2:0] v);
        exp_t e;
        e.name = n;
        e.d    = d;
        e.i    = i;
        e.v    = v;
        addr   = a;
        q.push_back(e);
        sample = 1'b1;
        cyc();
        sample = 1'b0;
    endtask

    task automatic st(input string n, input logic i,
                      input logic [1:0] s, input logic [2:0] v);
        chk(n, 2'd3, {11'd0, i, s, v}, i, v);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        addr = a;
        din  = d;
        wren = 1'b1;
        cyc();
        wren = 1'b0;
    endtask

    task automatic pulse(input int n);
        irq[n] = 1'b1;
        cyc();
        irq[n] = 1'b0;
    endtask

    task automatic ack();
        intack = 1'b1;
        cyc();
        intack = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        irq    = 8'h00;
        intack = 1'b0;
        wren   = 1'b0;
        addr   = 2'd0;
        din    = 16'h0000;
        cyc();
        chk("rst_mask", 2'd0, 16'h00FF, 1'b0, 3'd0);
        chk("rst_pend", 2'd1, 16'h0000, 1'b0, 3'd0);
        chk("rst_ins",  2'd2, 16'h0000, 1'b0, 3'd0);
        st("rst_stat", 1'b0, 2'd0, 3'd0);
        rst = 1'b0;
        cyc();

        // single pulse, ack
        pulse(6);
        chk("p6_pend", 2'd1, 16'h0040, 1'b0, 3'd0);
        st("p6_req", 1'b1, 2'd1, 3'd6);
        ack();
        chk("p6_ins", 2'd2, 16'h0040, 1'b0, 3'd6);
        chk("p6_pclr", 2'd1, 16'h0000, 1'b0, 3'd6);
        st("p6_idle", 1'b0, 2'd0, 3'd6);

        // nesting
        pulse(7);
        chk("nest_p7", 2'd1, 16'h0080, 1'b0, 3'd6);
        st("nest_blk", 1'b0, 2'd0, 3'd6);
        pulse(1);
        chk("nest_p1", 2'd1, 16'h0082, 1'b0, 3'd6);
        st("nest_req1", 1'b1, 2'd1, 3'd1);
        ack();
        chk("nest_ins42", 2'd2, 16'h0042, 1'b0, 3'd1);
        wr(2'd2, 16'h0000);
        chk("nest_eoi1", 2'd2, 16'h0040, 1'b0, 3'd1);
        wr(2'd2, 16'h0000);
        chk("nest_eoi2", 2'd2, 16'h0000, 1'b0, 3'd1);
        st("nest_req7", 1'b1, 2'd1, 3'd7);
        ack();
        chk("nest_ins80", 2'd2, 16'h0080, 1'b0, 3'd7);
        wr(2'd2, 16'h0000);
        chk("nest_clr", 2'd2, 16'h0000, 1'b0, 3'd7);

        // simultaneous sources
        irq = 8'h84;
        cyc();
        irq = 8'h00;
        cyc();
        st("dual_req2", 1'b1, 2'd1, 3'd2);
        ack();
        chk("dual_ins", 2'd2, 16'h0004, 1'b0, 3'd2);
        wr(2'd2, 16'h0000);
        st("dual_idle", 1'b0, 2'd0, 3'd2);
        st("dual_req7", 1'b1, 2'd1, 3'd7);
        ack();
        wr(2'd2, 16'h0000);

        // masking
        wr(2'd0, 16'h007F);
        pulse(7);
        chk("mask_pend", 2'd1, 16'h0080, 1'b0, 3'd7);
        st("mask_idle", 1'b0, 2'd0, 3'd7);
        wr(2'd0, 16'h00FF);
        chk("mask_rd", 2'd0, 16'h00FF, 1'b0, 3'd7);
        st("mask_req7", 1'b1, 2'd1, 3'd7);
        ack();
        wr(2'd2, 16'h0000);

        // rise wins over W1C, then W1C during REQ
        irq[3] = 1'b1;
        addr   = 2'd1;
        din    = 16'h0008;
        wren   = 1'b1;
        cyc();
        wren   = 1'b0;
        irq[3] = 1'b0;
        chk("w1c_setwin", 2'd1, 16'h0008, 1'b0, 3'd7);
        st("w1c_req3", 1'b1, 2'd1, 3'd3);
        wr(2'd1, 16'h0008);
        chk("w1c_inreq", 2'd1, 16'h0000, 1'b1, 3'd3);
        ack();
        chk("w1c_ins", 2'd2, 16'h0008, 1'b0, 3'd3);
        wr(2'd2, 16'h0000);
        chk("w1c_eoi", 2'd2, 16'h0000, 1'b0, 3'd3);

        // intack in IDLE
        intack = 1'b1;
        cyc();
        cyc();
        intack = 1'b0;
        st("idle_ack", 1'b0, 2'd0, 3'd3);
        chk("idle_ins", 2'd2, 16'h0000, 1'b0, 3'd3);

        // EOI + ack + re-rise in one cycle
        pulse(5);
        cyc();
        st("sim_req5", 1'b1, 2'd1, 3'd5);
        ack();
        pulse(2);
        cyc();
        st("sim_req2", 1'b1, 2'd1, 3'd2);
        addr   = 2'd2;
        wren   = 1'b1;
        intack = 1'b1;
        irq[2] = 1'b1;
        cyc();
        wren   = 1'b0;
        intack = 1'b0;
        irq[2] = 1'b0;
        chk("sim_ins", 2'd2, 16'h0004, 1'b0, 3'd2);
        chk("sim_pend", 2'd1, 16'h0004, 1'b0, 3'd2);
        wr(2'd1, 16'h00FF);
        wr(2'd2, 16'h0000);
        st("sim_idle", 1'b0, 2'd0, 3'd2);

        // reset mid-REQ with held line
        wr(2'd0, 16'h00F0);
        irq[4] = 1'b1;
        cyc();
        cyc();
        st("rr_req4", 1'b1, 2'd1, 3'd4);
        rst = 1'b1;
        st("rr_stat", 1'b0, 2'd0, 3'd0);
        chk("rr_mask", 2'd0, 16'h00FF, 1'b0, 3'd0);
        chk("rr_pend", 2'd1, 16'h0000, 1'b0, 3'd0);
        chk("rr_ins",  2'd2, 16'h0000, 1'b0, 3'd0);
        rst = 1'b0;
        cyc();
        chk("rr_repend", 2'd1, 16'h0010, 1'b0, 3'd0);
        st("rr_rereq", 1'b1, 2'd1, 3'd4);
        irq = 8'h00;
        ack();
        wr(2'd2, 16'h0000);
        chk("rr_end", 2'd2, 16'h0000, 1'b0, 3'd4);

        repeat (3) cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
